g1_backend_exe_mem_wb: RTL and testbench

// - Consumer side of the decode-stage interface: captures ID control/operand outputs, runs EXE, MEM, WB.
// - Returns regfile write port (writeEn/dest/writeVal), hazard feedback (dest_EXE, dest_MEM,
//   WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE) and flagZ to the decode stage. Three-stage pipe, owns data memory.

---
 rtl/g1_backend_exe_mem_wb_if.sv | 47 ++++
 rtl/g1_backend_exe_mem_wb.sv | 239 +++++++++++++++++++++++
 tb/tb_g1_backend_exe_mem_wb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/g1_backend_exe_mem_wb_if.sv
// Decode-to-backend interface: ID control/operand bundle going into the
// EXE/MEM/WB pipe, and the writeback / hazard / flag feedback coming back.
// master = decode stage, slave = backend pipe.
interface g1_backend_exe_mem_wb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CMD_W  = 4
);
  // decode -> backend
  logic              hazard_detected;
  logic [CMD_W-1:0]  EXE_CMD;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              WB_EN;
  logic              is_imm;
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] st_val;

  // backend -> decode
  logic [ADDR_W-1:0] dest_EXE;
  logic              WB_EN_EXE;
  logic              MEM_R_EN_EXE;
  logic [ADDR_W-1:0] dest_MEM;
  logic              WB_EN_MEM;
  logic              writeEn;
  logic [ADDR_W-1:0] dest_WB;
  logic [DATA_W-1:0] writeVal;
  logic              flagZ;

  modport master (
    output hazard_detected, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, is_imm,
           src1, src2, dest, val1, val2, st_val,
    input  dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           writeEn, dest_WB, writeVal, flagZ
  );

  modport slave (
    input  hazard_detected, EXE_CMD, MEM_R_EN, MEM_W_EN, WB_EN, is_imm,
           src1, src2, dest, val1, val2, st_val,
    output dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           writeEn, dest_WB, writeVal, flagZ
  );
endinterface

// File: rtl/g1_backend_exe_mem_wb.sv
// Backend pipe EXE -> MEM -> WB fed by the decode stage. Owns the data
// memory, produces the regfile write port, hazard feedback and flagZ.
// Optional EXE operand forwarding is compiled in when G1_BACKEND_FWD_EN
// is defined; otherwise captured operands are used as-is.
module g1_backend_exe_mem_wb #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int CMD_W      = 4,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  g1_backend_exe_mem_wb_if.slave  id_if
);

  localparam int MEM_AW = $clog2(DMEM_DEPTH);

  localparam logic [CMD_W-1:0] CMD_NOP = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_OR  = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_XOR = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_SHL = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_SHR = CMD_W'(7);
  localparam logic [CMD_W-1:0] CMD_PSB = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_CMP = CMD_W'(9);

  // ID/EXE
  logic [CMD_W-1:0]  cmd_exe_q;
  logic              mem_r_en_exe_q, mem_w_en_exe_q, wb_en_exe_q;
  logic [ADDR_W-1:0] dest_exe_q;
  logic [DATA_W-1:0] val1_exe_q, val2_exe_q, st_val_exe_q;
`ifdef G1_BACKEND_FWD_EN
  logic              is_imm_exe_q;
  logic [ADDR_W-1:0] src1_exe_q, src2_exe_q;
`endif

  // EXE/MEM
  logic [DATA_W-1:0] res_mem_q, st_data_mem_q;
  logic [ADDR_W-1:0] dest_mem_q;
  logic              wb_en_mem_q, mem_r_en_mem_q, mem_w_en_mem_q;

  // MEM/WB
  logic [DATA_W-1:0] write_val_wb_q;
  logic [ADDR_W-1:0] dest_wb_q;
  logic              wb_en_wb_q;

  logic              flagz_q, flagz_d;
  logic [DATA_W-1:0] write_val_d;

  // EXE datapath
  logic [DATA_W-1:0] op_a_s, op_b_s, st_data_s, res_s;
  logic              flag_upd_s;

  // data memory (intentionally not reset)
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
  logic [MEM_AW-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // ID/EXE capture; a hazard turns the slot into a side-effect-free bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_exe_q      <= CMD_NOP;
      mem_r_en_exe_q <= 1'b0;
      mem_w_en_exe_q <= 1'b0;
      wb_en_exe_q    <= 1'b0;
      dest_exe_q     <= '0;
      val1_exe_q     <= '0;
      val2_exe_q     <= '0;
      st_val_exe_q   <= '0;
    end else if (id_if.hazard_detected) begin
      cmd_exe_q      <= CMD_NOP;
      mem_r_en_exe_q <= 1'b0;
      mem_w_en_exe_q <= 1'b0;
      wb_en_exe_q    <= 1'b0;
      dest_exe_q     <= '0;
      val1_exe_q     <= '0;
      val2_exe_q     <= '0;
      st_val_exe_q   <= '0;
    end else begin
      cmd_exe_q      <= id_if.EXE_CMD;
      mem_r_en_exe_q <= id_if.MEM_R_EN;
      mem_w_en_exe_q <= id_if.MEM_W_EN;
      wb_en_exe_q    <= id_if.WB_EN;
      dest_exe_q     <= id_if.dest;
      val1_exe_q     <= id_if.val1;
      val2_exe_q     <= id_if.val2;
      st_val_exe_q   <= id_if.st_val;
    end
  end

`ifdef G1_BACKEND_FWD_EN
  // ID/EXE capture of the forwarding-compare fields (src regs are zero in a bubble)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_imm_exe_q <= 1'b0;
      src1_exe_q   <= '0;
      src2_exe_q   <= '0;
    end else if (id_if.hazard_detected) begin
      is_imm_exe_q <= 1'b0;
      src1_exe_q   <= '0;
      src2_exe_q   <= '0;
    end else begin
      is_imm_exe_q <= id_if.is_imm;
      src1_exe_q   <= id_if.src1;
      src2_exe_q   <= id_if.src2;
    end
  end

  // operand forwarding: MEM result beats WB value; loads in MEM cannot forward yet
  always_comb begin
    op_a_s    = val1_exe_q;
    op_b_s    = val2_exe_q;
    st_data_s = st_val_exe_q;
    if (wb_en_mem_q && !mem_r_en_mem_q && (src1_exe_q == dest_mem_q)) begin
      op_a_s = res_mem_q;
    end else if (wb_en_wb_q && (src1_exe_q == dest_wb_q)) begin
      op_a_s = write_val_wb_q;
    end else begin
      op_a_s = val1_exe_q;
    end
    if (is_imm_exe_q) begin
      op_b_s = val2_exe_q;
    end else if (wb_en_mem_q && !mem_r_en_mem_q && (src2_exe_q == dest_mem_q)) begin
      op_b_s = res_mem_q;
    end else if (wb_en_wb_q && (src2_exe_q == dest_wb_q)) begin
      op_b_s = write_val_wb_q;
    end else begin
      op_b_s = val2_exe_q;
    end
    if (wb_en_mem_q && !mem_r_en_mem_q && (src2_exe_q == dest_mem_q)) begin
      st_data_s = res_mem_q;
    end else if (wb_en_wb_q && (src2_exe_q == dest_wb_q)) begin
      st_data_s = write_val_wb_q;
    end else begin
      st_data_s = st_val_exe_q;
    end
  end
`else
  // no forwarding: operands exactly as captured from ID
  always_comb begin
    op_a_s    = val1_exe_q;
    op_b_s    = val2_exe_q;
    st_data_s = st_val_exe_q;
  end
`endif

  // ALU; unused opcodes 10-15 behave as NOP
  always_comb begin
    res_s = '0;
    case (cmd_exe_q)
      CMD_ADD: res_s = op_a_s + op_b_s;
      CMD_SUB: res_s = op_a_s - op_b_s;
      CMD_AND: res_s = op_a_s & op_b_s;
      CMD_OR:  res_s = op_a_s | op_b_s;
      CMD_XOR: res_s = op_a_s ^ op_b_s;
      CMD_SHL: res_s = op_a_s << op_b_s[3:0];
      CMD_SHR: res_s = op_a_s >> op_b_s[3:0];
      CMD_PSB: res_s = op_b_s;
      CMD_CMP: res_s = op_a_s - op_b_s;
      default: res_s = '0;
    endcase
  end

  // zero flag follows real ALU ops only; memory ops use ADD for addressing and must not disturb it
  always_comb begin
    flag_upd_s = (cmd_exe_q >= CMD_ADD) && (cmd_exe_q <= CMD_CMP) &&
                 !mem_r_en_exe_q && !mem_w_en_exe_q;
    if (flag_upd_s) begin
      flagz_d = (res_s == '0);
    end else begin
      flagz_d = flagz_q;
    end
  end

  // flag register and EXE/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagz_q        <= 1'b0;
      res_mem_q      <= '0;
      st_data_mem_q  <= '0;
      dest_mem_q     <= '0;
      wb_en_mem_q    <= 1'b0;
      mem_r_en_mem_q <= 1'b0;
      mem_w_en_mem_q <= 1'b0;
    end else begin
      flagz_q        <= flagz_d;
      res_mem_q      <= res_s;
      st_data_mem_q  <= st_data_s;
      dest_mem_q     <= dest_exe_q;
      wb_en_mem_q    <= wb_en_exe_q;
      mem_r_en_mem_q <= mem_r_en_exe_q;
      mem_w_en_mem_q <= mem_w_en_exe_q;
    end
  end

  // address wraps to memory size; read is combinational so a store one cycle earlier is visible
  always_comb begin
    mem_addr_s  = res_mem_q[MEM_AW-1:0];
    mem_rdata_s = dmem_q[mem_addr_s];
    if (mem_r_en_mem_q) begin
      write_val_d = mem_rdata_s;
    end else begin
      write_val_d = res_mem_q;
    end
  end

  // data memory write on the edge the store leaves MEM (reset has already cleared the enable)
  always_ff @(posedge clk) begin
    if (mem_w_en_mem_q) begin
      dmem_q[mem_addr_s] <= st_data_mem_q;
    end
  end

  // MEM/WB register; load-vs-result choice is made before the flop so writeVal is a clean register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_val_wb_q <= '0;
      dest_wb_q      <= '0;
      wb_en_wb_q     <= 1'b0;
    end else begin
      write_val_wb_q <= write_val_d;
      dest_wb_q      <= dest_mem_q;
      wb_en_wb_q     <= wb_en_mem_q;
    end
  end

  assign id_if.dest_EXE     = dest_exe_q;
  assign id_if.WB_EN_EXE    = wb_en_exe_q;
  assign id_if.MEM_R_EN_EXE = mem_r_en_exe_q;
  assign id_if.dest_MEM     = dest_mem_q;
  assign id_if.WB_EN_MEM    = wb_en_mem_q;
  assign id_if.writeEn      = wb_en_wb_q;
  assign id_if.dest_WB      = dest_wb_q;
  assign id_if.writeVal     = write_val_wb_q;
  assign id_if.flagZ        = flagz_q;

endmodule

// File: tb/tb_g1_backend_exe_mem_wb.sv
// Directed + randomized bench for g1_backend_exe_mem_wb. The reference model
// executes each captured op in program order (ALU arithmetic, memory array,
// flag, forwarding from the two previous ops) and keeps a short history from
// which the per-stage outputs are predicted.
module tb_g1_backend_exe_mem_wb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CMD_W  = 4;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  g1_backend_exe_mem_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W)) bif ();

  g1_backend_exe_mem_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_W(CMD_W), .DMEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .id_if (bif)
  );

  typedef struct {
    bit          hz;
    logic [3:0]  cmd;
    bit          mr, mw, wb, imm;
    logic [3:0]  s1, s2, d;
    logic [15:0] v1, v2, sv;
  } op_t;

  typedef struct {
    bit          wb;
    bit          mr;
    logic [3:0]  dest;
    logic [15:0] res;
    logic [15:0] wv;
    bit          fz;
  } ent_t;

  ent_t        hist[$];
  logic [15:0] mem_m [DEPTH];
  bit          fz_m;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [15:0] alu(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b);
    int ia, ib, sh;
    ia = int'(a); ib = int'(b); sh = ib % 16;
    case (int'(cmd))
      1:       return 16'((ia + ib) % 65536);
      2:       return 16'((ia - ib + 65536) % 65536);
      3:       return a & b;
      4:       return a | b;
      5:       return a ^ b;
      6:       return 16'((ia * (2 ** sh)) % 65536);
      7:       return 16'(ia / (2 ** sh));
      8:       return b;
      9:       return 16'((ia - ib + 65536) % 65536);
      default: return 16'h0000;
    endcase
  endfunction

  // value a reader of register s sees: previous op (now in MEM, not a load), then the one before (in WB)
  function automatic logic [15:0] fwd(input logic [3:0] s, input logic [15:0] dflt);
`ifdef G1_BACKEND_FWD_EN
    ent_t m, w;
    m = hist[$];
    w = hist[$-1];
    if (m.wb && !m.mr && m.dest == s) return m.res;
    if (w.wb && w.dest == s) return w.wv;
`endif
    return dflt + 16'h0000 + ({12'h000, s} & 16'h0000);
  endfunction

  task automatic model_reset();
    ent_t z;
    z = '{wb: 1'b0, mr: 1'b0, dest: 4'h0, res: 16'h0000, wv: 16'h0000, fz: 1'b0};
    hist.delete();
    fz_m = 1'b0;
    for (int i = 0; i < 3; i++) hist.push_back(z);
  endtask

  task automatic model_capture(input op_t o);
    ent_t e;
    logic [15:0] a, b, sd, r;
    if (o.hz) begin
      e = '{wb: 1'b0, mr: 1'b0, dest: 4'h0, res: 16'h0000, wv: 16'h0000, fz: fz_m};
    end else begin
      a  = fwd(o.s1, o.v1);
      b  = o.imm ? o.v2 : fwd(o.s2, o.v2);
      sd = fwd(o.s2, o.sv);
      r  = alu(o.cmd, a, b);
      if (o.cmd >= 4'd1 && o.cmd <= 4'd9 && !o.mr && !o.mw) fz_m = (r == 16'h0000);
      e.wb = o.wb; e.mr = o.mr; e.dest = o.d; e.res = r;
      e.wv = o.mr ? mem_m[int'(r) % DEPTH] : r;
      if (o.mw) mem_m[int'(r) % DEPTH] = sd;
      e.fz = fz_m;
    end
    hist.push_back(e);
    if (hist.size() > 6) void'(hist.pop_front());
  endtask

  task automatic check_outputs();
    ent_t e, m, w;
    e = hist[$]; m = hist[$-1]; w = hist[$-2];
    chk("dest_EXE",     32'(bif.dest_EXE),     32'(e.dest));
    chk("WB_EN_EXE",    32'(bif.WB_EN_EXE),    32'(e.wb));
    chk("MEM_R_EN_EXE", 32'(bif.MEM_R_EN_EXE), 32'(e.mr));
    chk("dest_MEM",     32'(bif.dest_MEM),     32'(m.dest));
    chk("WB_EN_MEM",    32'(bif.WB_EN_MEM),    32'(m.wb));
    chk("writeEn",      32'(bif.writeEn),      32'(w.wb));
    chk("dest_WB",      32'(bif.dest_WB),      32'(w.dest));
    chk("writeVal",     32'(bif.writeVal),     32'(w.wv));
    chk("flagZ",        32'(bif.flagZ),        32'(m.fz));
  endtask

  task automatic drive(input op_t o);
    bif.hazard_detected = o.hz;
    bif.EXE_CMD = o.cmd; bif.MEM_R_EN = o.mr; bif.MEM_W_EN = o.mw; bif.WB_EN = o.wb;
    bif.is_imm = o.imm; bif.src1 = o.s1; bif.src2 = o.s2; bif.dest = o.d;
    bif.val1 = o.v1; bif.val2 = o.v2; bif.st_val = o.sv;
  endtask

  task automatic step(input op_t o);
    drive(o);
    @(posedge clk);
    model_capture(o);
    #1;
    check_outputs();
  endtask

  function automatic op_t alu_op(input logic [3:0] cmd, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] d, input bit wb);
    op_t o;
    o.hz = 1'b0; o.cmd = cmd; o.mr = 1'b0; o.mw = 1'b0; o.wb = wb; o.imm = 1'b0;
    o.s1 = 4'hF; o.s2 = 4'hF; o.d = d; o.v1 = a; o.v2 = b; o.sv = 16'h0000;
    return o;
  endfunction

  function automatic op_t nop_op();
    return alu_op(4'd0, 16'h0000, 16'h0000, 4'h0, 1'b0);
  endfunction

  function automatic op_t ld_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
    op_t o;
    o = alu_op(4'd1, a, b, d, 1'b1);
    o.mr = 1'b1;
    return o;
  endfunction

  function automatic op_t st_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] sv);
    op_t o;
    o = alu_op(4'd1, a, b, 4'h0, 1'b0);
    o.mw = 1'b1; o.sv = sv;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    k = int'($urandom_range(0, 9));
    o = alu_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
               4'($urandom_range(0, 15)), 1'($urandom));
    o.s1 = 4'($urandom_range(0, 15)); o.s2 = 4'($urandom_range(0, 15));
    o.imm = 1'($urandom); o.sv = 16'($urandom);
    if (k == 0) begin
      o.hz = 1'b1; o.wb = 1'b1;
    end else if (k <= 2) begin
      o.cmd = 4'd1; o.mr = 1'b1;
    end else if (k == 3) begin
      o.cmd = 4'd1; o.mw = 1'b1; o.wb = 1'b0;
    end
    return o;
  endfunction

  initial begin
    op_t o;

    // reset state
    rst = 1'b1;
    drive(nop_op());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("rst_writeEn",   32'(bif.writeEn),   32'd0);
    chk("rst_writeVal",  32'(bif.writeVal),  32'd0);
    chk("rst_dest_EXE",  32'(bif.dest_EXE),  32'd0);
    chk("rst_WB_EN_MEM", 32'(bif.WB_EN_MEM), 32'd0);
    chk("rst_flagZ",     32'(bif.flagZ),     32'd0);

    // ADD overflow into bit 15, then a hazard bubble with WB_EN presented
    step(alu_op(4'd1, 16'h7FFF, 16'h0001, 4'd3, 1'b1));
    o = alu_op(4'd1, 16'h1111, 16'h2222, 4'd9, 1'b1);
    o.hz = 1'b1;
    step(o);
    chk("hz_WB_EN_EXE", 32'(bif.WB_EN_EXE), 32'd0);
    step(nop_op());
    chk("add_writeEn",  32'(bif.writeEn),  32'd1);
    chk("add_dest_WB",  32'(bif.dest_WB),  32'd3);
    chk("add_writeVal", 32'(bif.writeVal), 32'h8000);
    step(nop_op());
    chk("hz_no_pulse", 32'(bif.writeEn), 32'd0);

    // flag behaviour and store/load through the wrapping address
    step(alu_op(4'd9, 16'h0042, 16'h0042, 4'd0, 1'b0));
    step(st_op(16'h0100, 16'h0005, 16'hBEEF));
    chk("cmp_flagZ", 32'(bif.flagZ), 32'd1);
    step(ld_op(16'h0005, 16'h0000, 4'd7));
    chk("st_hold_flagZ", 32'(bif.flagZ), 32'd1);
    step(alu_op(4'd2, 16'h0005, 16'h0003, 4'd0, 1'b0));
    chk("ld_hold_flagZ", 32'(bif.flagZ), 32'd1);
    step(nop_op());
    chk("sub_flagZ",   32'(bif.flagZ),    32'd0);
    chk("ld_writeEn",  32'(bif.writeEn),  32'd1);
    chk("ld_dest_WB",  32'(bif.dest_WB),  32'd7);
    chk("ld_writeVal", 32'(bif.writeVal), 32'hBEEF);

    // back-to-back dependent ADDs
    step(alu_op(4'd1, 16'h0002, 16'h0003, 4'd1, 1'b1));
    o = alu_op(4'd1, 16'h0000, 16'h0001, 4'd2, 1'b1);
    o.s1 = 4'd1;
    step(o);
    step(nop_op());
    chk("fwd_first", 32'(bif.writeVal), 32'd5);
    step(nop_op());
`ifdef G1_BACKEND_FWD_EN
    chk("fwd_second", 32'(bif.writeVal), 32'd6);
`else
    chk("fwd_second", 32'(bif.writeVal), 32'd1);
`endif

    // asynchronous reset between edges with writers in flight
    step(alu_op(4'd1, 16'h0010, 16'h0020, 4'd4, 1'b1));
    step(alu_op(4'd9, 16'h0001, 16'h0001, 4'd5, 1'b1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_writeEn",   32'(bif.writeEn),   32'd0);
    chk("mid_rst_WB_EN_EXE", 32'(bif.WB_EN_EXE), 32'd0);
    chk("mid_rst_dest_MEM",  32'(bif.dest_MEM),  32'd0);
    chk("mid_rst_writeVal",  32'(bif.writeVal),  32'd0);
    chk("mid_rst_flagZ",     32'(bif.flagZ),     32'd0);
    #1 rst = 1'b0;
    model_reset();
    step(nop_op());
    step(nop_op());
    chk("post_rst_no_write", 32'(bif.writeEn), 32'd0);
    step(nop_op());
    chk("post_rst_no_write2", 32'(bif.writeEn), 32'd0);

    // give every memory word a known value, then random traffic
    for (int i = 0; i < DEPTH; i++) step(st_op(16'(i), 16'h0000, 16'($urandom)));
    for (int i = 0; i < 600; i++) step(rand_op());
    for (int i = 0; i < 3; i++) step(nop_op());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
